// File: rtl/user_led_ctrl.sv
// -----------------------------------------------------------------------------
// user_led_ctrl
//   Multi-channel LED/indicator driver. Each of NUM_CH channels can be off,
//   follow its (synchronised) input, PWM-dim or blink, with optional output
//   inversion. Configuration is written over a zero-wait AHB-lite slave port.
//
// Ports
//   sys_clock            sole clock, rising edge
//   reset                synchronous, active-high
//   chn_in[NUM_CH]       per-channel source, asynchronous to sys_clock
//   mem_ahb_htrans       transfer type (bit1 = NONSEQ/SEQ)
//   mem_ahb_hready       bus ready; address phase taken only when high
//   mem_ahb_hwrite       1 = write
//   mem_ahb_haddr        byte address, only [7:0] decoded
//   mem_ahb_hsize        ignored (all accesses are 32-bit)
//   mem_ahb_hwdata       write data (data phase)
//   mem_ahb_hreadyout    always 1 (no wait states)
//   mem_ahb_hresp        always 0 (OKAY)
//   mem_ahb_hrdata       read data (data phase), 0 otherwise
//   led_out[NUM_CH]      registered LED drive
//
// Register map (byte offsets)
//   0x00     CTRL      bit0 EN
//   0x04     PRESCALE  [PRESCALE_BITS-1:0]
//   0x10+8n  CFG(n)    [2:0] MODE, bit3 INV
//   0x14+8n  DUTY(n)   [PWM_BITS-1:0]
// -----------------------------------------------------------------------------
module user_led_ctrl #(
  parameter int NUM_CH        = 2,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    chn_in,
  input  logic [1:0]           mem_ahb_htrans,
  input  logic                 mem_ahb_hready,
  input  logic                 mem_ahb_hwrite,
  input  logic [31:0]          mem_ahb_haddr,
  input  logic [2:0]           mem_ahb_hsize,
  input  logic [31:0]          mem_ahb_hwdata,
  output logic                 mem_ahb_hreadyout,
  output logic                 mem_ahb_hresp,
  output logic [31:0]          mem_ahb_hrdata,
  output logic [NUM_CH-1:0]    led_out
);

  localparam logic [PWM_BITS-1:0]      PWM_MAX = '1;
  localparam logic [PWM_BITS-1:0]      PWM_ONE = 1;
  localparam logic [PRESCALE_BITS-1:0] PRE_ONE = 1;

  localparam logic [2:0] MODE_FOLLOW = 3'd1;
  localparam logic [2:0] MODE_PWM    = 3'd2;
  localparam logic [2:0] MODE_BLINK  = 3'd3;

  // ---------------------------------------------------------------------------
  // AHB-lite slave: register the address phase, act in the data phase
  // ---------------------------------------------------------------------------
  logic       dp_valid;
  logic       dp_write;
  logic [7:0] dp_addr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesised registers.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else if (mem_ahb_hready) begin
      dp_valid <= mem_ahb_htrans[1];
      dp_write <= mem_ahb_hwrite;
      dp_addr  <= mem_ahb_haddr[7:0];
    end
  end

  assign mem_ahb_hreadyout = 1'b1;
  assign mem_ahb_hresp     = 1'b0;

  // Word decode of the data-phase address. Channel words start at word 4 and
  // come in CFG/DUTY pairs, so word[0] picks DUTY and word[5:1]-2 is the channel.
  logic [5:0] word;
  logic       is_ctrl;
  logic       is_pre;
  logic       is_ch;
  logic       is_duty;
  logic [4:0] ch_idx;
  logic       wr_en;
  logic       rd_en;

  assign word    = dp_addr[7:2];
  assign is_ctrl = (word == 6'd0);
  assign is_pre  = (word == 6'd1);
  assign is_ch   = (word >= 6'd4);
  assign is_duty = word[0];
  assign ch_idx  = word[5:1] - 5'd2;
  assign wr_en   = dp_valid && dp_write && mem_ahb_hready;
  assign rd_en   = dp_valid && !dp_write;

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic                     en_q;
  logic [PRESCALE_BITS-1:0] prescale_q;
  logic [3:0]               cfg_q  [NUM_CH];
  logic [PWM_BITS-1:0]      duty_q [NUM_CH];
  logic                     pre_wr;

  assign pre_wr = wr_en && is_pre;

  // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they
  // are reset explicitly; software relies on every channel starting OFF.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      en_q       <= 1'b0;
      prescale_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cfg_q[i]  <= '0;
        duty_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (is_ctrl) en_q       <= mem_ahb_hwdata[0];
      if (is_pre)  prescale_q <= mem_ahb_hwdata[PRESCALE_BITS-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (is_ch && ch_idx == 5'(i)) begin
          if (is_duty) duty_q[i] <= mem_ahb_hwdata[PWM_BITS-1:0];
          else         cfg_q[i]  <= mem_ahb_hwdata[3:0];
        end
      end
    end
  end

  // Read mux: zero outside a read data phase and for any unmapped word.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_ahb_hrdata = '0;
    if (rd_en) begin
      if (is_ctrl) mem_ahb_hrdata = {31'd0, en_q};
      if (is_pre)  mem_ahb_hrdata = 32'(prescale_q);
      for (int i = 0; i < NUM_CH; i++) begin
        if (is_ch && ch_idx == 5'(i)) begin
          mem_ahb_hrdata = is_duty ? 32'(duty_q[i]) : 32'(cfg_q[i]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared tick / PWM / blink timebase. Held at zero while disabled; a
  // PRESCALE write restarts it so the new rate begins from a clean phase.
  // ---------------------------------------------------------------------------
  logic [PRESCALE_BITS-1:0] pre_cnt;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic                     blink_q;
  logic                     tick;

  assign tick = (pre_cnt == prescale_q);

  always_ff @(posedge sys_clock) begin
    if (reset || !en_q || pre_wr) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      blink_q <= 1'b0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + PWM_ONE;
      if (pwm_cnt == PWM_MAX) blink_q <= ~blink_q;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser and per-channel output
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] inv;

  always_comb begin
    level = '0;
    inv   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      inv[i] = cfg_q[i][3];
      case (cfg_q[i][2:0])
        MODE_FOLLOW: level[i] = sync2_q[i];
        MODE_PWM:    level[i] = (pwm_cnt < duty_q[i]);
        MODE_BLINK:  level[i] = blink_q;
        default:     level[i] = 1'b0;  // OFF and reserved modes 4..7
      endcase
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      led_out <= '0;
    end else begin
      sync1_q <= chn_in;
      sync2_q <= sync1_q;
      // Disabled forces the pins low even on inverted channels.
      led_out <= en_q ? (level ^ inv) : '0;
    end
  end

  // Bus fields this slave deliberately does not decode.
  logic unused_bits;
  assign unused_bits = ^{mem_ahb_hsize, mem_ahb_haddr[31:8], mem_ahb_htrans[0],
                         mem_ahb_hwdata, dp_addr[1:0]};

endmodule

// File: tb/tb_user_led_ctrl.sv
`timescale 1ns/1ps
module tb_user_led_ctrl;

  localparam int NUM_CH        = 2;
  localparam int PWM_BITS      = 8;
  localparam int PRESCALE_BITS = 16;

  logic              sys_clock = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] chn_in;
  logic [1:0]        htrans;
  logic              hready;
  logic              hwrite;
  logic [31:0]       haddr;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic              hreadyout;
  logic              hresp;
  logic [31:0]       hrdata;
  logic [NUM_CH-1:0] led_out;

  always #5 sys_clock = ~sys_clock;

  user_led_ctrl #(
    .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESCALE_BITS(PRESCALE_BITS)
  ) dut (
    .sys_clock         (sys_clock),
    .reset             (reset),
    .chn_in            (chn_in),
    .mem_ahb_htrans    (htrans),
    .mem_ahb_hready    (hready),
    .mem_ahb_hwrite    (hwrite),
    .mem_ahb_haddr     (haddr),
    .mem_ahb_hsize     (hsize),
    .mem_ahb_hwdata    (hwdata),
    .mem_ahb_hreadyout (hreadyout),
    .mem_ahb_hresp     (hresp),
    .mem_ahb_hrdata    (hrdata),
    .led_out           (led_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // hreadyout/hresp must hold their constants on every cycle.
  int bus_bad = 0;
  always @(negedge sys_clock) begin
    if (hreadyout !== 1'b1 || hresp !== 1'b0) bus_bad++;
  end

  // Read scoreboard: expectation pushed with the address phase, popped in the
  // data phase.
  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  task automatic sb_check();
    rd_exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got hrdata 0x%08h with nothing expected", hrdata);
    end else begin
      e = sb_q.pop_front();
      check(e.name, hrdata, e.exp);
    end
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge sys_clock); #1;
    htrans = 2'b10; hwrite = 1'b1; haddr = {24'h600000, a};
    @(posedge sys_clock); #1;
    htrans = 2'b00; hwrite = 1'b0; hwdata = d;
  endtask

  task automatic ahb_read(input logic [7:0] a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    @(posedge sys_clock); #1;
    htrans = 2'b10; hwrite = 1'b0; haddr = {24'h600000, a};
    e.exp = exp; e.name = name;
    sb_q.push_back(e);
    @(posedge sys_clock); #1;
    htrans = 2'b00;
    @(negedge sys_clock);
    sb_check();
  endtask

  // Number of falling clock edges until led_out[b] == v; max+1 on timeout.
  task automatic wait_led(input int b, input logic v, input int max, output int cyc);
    cyc = max + 1;
    for (int k = 1; k <= max; k++) begin
      @(negedge sys_clock);
      if (led_out[b] === v) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic count_high(input int b, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clock);
      if (led_out[b] === 1'b1) cnt++;
    end
  endtask

  typedef struct {
    logic        do_wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } reg_vec_t;

  reg_vec_t    vecs [12];
  logic [7:0]  map_offs [6];
  logic [1:0]  follow_pat [4];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, h, l, fk, rk;
    logic [1:0] exp_led, prev_led;

    vecs[0]  = '{1'b1, 8'h04, 32'hFFFF_1234, 32'h0000_1234, "rw_prescale"};
    vecs[1]  = '{1'b1, 8'h10, 32'hFFFF_FFFF, 32'h0000_000F, "rw_cfg0"};
    vecs[2]  = '{1'b1, 8'h14, 32'h1234_56AB, 32'h0000_00AB, "rw_duty0"};
    vecs[3]  = '{1'b1, 8'h18, 32'h0000_0007, 32'h0000_0007, "rw_cfg1_mode7"};
    vecs[4]  = '{1'b1, 8'h1C, 32'hFFFF_FF80, 32'h0000_0080, "rw_duty1"};
    vecs[5]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0000_0000, "rw_unmapped_08"};
    vecs[6]  = '{1'b1, 8'h20, 32'hFFFF_FFFF, 32'h0000_0000, "rw_cfg_n2"};
    vecs[7]  = '{1'b1, 8'h24, 32'hFFFF_FFFF, 32'h0000_0000, "rw_duty_n2"};
    vecs[8]  = '{1'b0, 8'h10, 32'h0,         32'h0000_000F, "cfg0_not_aliased"};
    vecs[9]  = '{1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0000_0000, "rw_unmapped_0c"};
    vecs[10] = '{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0000_0001, "rw_ctrl_en1"};
    vecs[11] = '{1'b1, 8'h00, 32'hFFFF_FFFE, 32'h0000_0000, "rw_ctrl_en0"};
    map_offs   = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h1C};
    follow_pat = '{2'b11, 2'b01, 2'b10, 2'b00};

    reset = 1'b1; chn_in = '0; htrans = 2'b00; hready = 1'b1; hwrite = 1'b0;
    haddr = '0; hsize = 3'b010; hwdata = '0;
    repeat (3) @(posedge sys_clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge sys_clock);
    check("reset_led", 32'(led_out), 32'h0);
    check("reset_hrdata_idle", hrdata, 32'h0);
    for (int i = 0; i < 6; i++) ahb_read(map_offs[i], 32'h0, "reset_readback");

    // Register read/write table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) ahb_write(vecs[i].addr, vecs[i].wdata);
      ahb_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    check("en0_inv_forced_low", 32'(led_out), 32'h0);

    // Reserved mode 7 behaves as OFF: ch0 (INV) high, ch1 low
    ahb_write(8'h00, 32'h1);
    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    check("mode7_off_with_inv", 32'(led_out), 32'h1);

    // FOLLOW: ch0 plain, ch1 inverted, 3-cycle latency
    ahb_write(8'h10, 32'h1);
    ahb_write(8'h18, 32'h9);
    repeat (4) @(posedge sys_clock);
    @(negedge sys_clock);
    prev_led = 2'b10;
    check("follow_idle", 32'(led_out), 32'(prev_led));
    for (int i = 0; i < 4; i++) begin
      exp_led = {~follow_pat[i][1], follow_pat[i][0]};
      @(posedge sys_clock); #1;
      chn_in = follow_pat[i];
      @(posedge sys_clock);
      @(posedge sys_clock);
      @(negedge sys_clock);
      check("follow_before_3cyc", 32'(led_out), 32'(prev_led));
      @(posedge sys_clock);
      @(negedge sys_clock);
      check("follow_at_3cyc", 32'(led_out), 32'(exp_led));
      prev_led = exp_led;
    end

    // PWM, PRESCALE=0, DUTY=64
    ahb_write(8'h18, 32'h0);
    ahb_write(8'h10, 32'h2);
    ahb_write(8'h14, 32'd64);
    ahb_write(8'h04, 32'h0);
    wait_led(0, 1'b0, 600, c);
    wait_led(0, 1'b1, 600, c);
    wait_led(0, 1'b0, 600, h);
    check("pwm64_high_len", 32'(h), 32'd64);
    wait_led(0, 1'b1, 600, l);
    check("pwm64_low_len", 32'(l), 32'd192);
    count_high(0, 512, c);
    check("pwm64_high_in_512", 32'(c), 32'd128);

    ahb_write(8'h14, 32'd255);
    repeat (3) @(posedge sys_clock);
    count_high(0, 512, c);
    check("pwm255_high_in_512", 32'(c), 32'd510);

    ahb_write(8'h14, 32'd0);
    repeat (3) @(posedge sys_clock);
    count_high(0, 300, c);
    check("pwm0_const_low", 32'(c), 32'd0);

    // BLINK, PRESCALE=1: toggle every 512 cycles
    ahb_write(8'h10, 32'h3);
    ahb_write(8'h04, 32'h1);
    wait_led(0, 1'b0, 1200, c);
    wait_led(0, 1'b1, 1200, c);
    wait_led(0, 1'b0, 1200, h);
    check("blink_half_period", 32'(h), 32'd512);
    wait_led(0, 1'b1, 1200, c);
    repeat (100) @(negedge sys_clock);
    // PRESCALE rewrite mid-period: blink_q clears at the commit edge, so the
    // LED drops one cycle later and rises a full half period after that.
    ahb_write(8'h04, 32'h1);
    @(posedge sys_clock);
    wait_led(0, 1'b0, 1200, fk);
    check("prescale_wr_clear_fall", 32'(fk), 32'd2);
    wait_led(0, 1'b1, 1200, rk);
    check("prescale_wr_next_toggle", 32'(rk), 32'd512);

    // EN clear with PWM and inverted BLINK running, then re-enable
    ahb_write(8'h04, 32'h0);
    ahb_write(8'h10, 32'h2);
    ahb_write(8'h14, 32'd128);
    ahb_write(8'h18, 32'hB);
    repeat (40) @(posedge sys_clock);
    ahb_write(8'h00, 32'h0);
    @(posedge sys_clock);
    @(posedge sys_clock);
    @(negedge sys_clock);
    check("en_off_next_cycle", 32'(led_out), 32'h0);
    repeat (30) @(posedge sys_clock);
    @(negedge sys_clock);
    check("en_off_held", 32'(led_out), 32'h0);
    ahb_write(8'h00, 32'h1);
    @(posedge sys_clock);
    @(negedge sys_clock);
    @(negedge sys_clock);
    check("en_restart_led", 32'(led_out), 32'h3);
    wait_led(0, 1'b0, 300, h);
    check("en_restart_pwm_from_0", 32'(h), 32'd128);

    // Back-to-back write then read of DUTY0, no wait state
    @(posedge sys_clock); #1;
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h6000_0014;
    @(posedge sys_clock); #1;
    hwdata = 32'hFFFF_FF5A;
    htrans = 2'b10; hwrite = 1'b0; haddr = 32'h6000_0014;
    begin
      rd_exp_t e;
      e.exp = 32'h0000_005A; e.name = "b2b_wr_rd_duty0";
      sb_q.push_back(e);
    end
    @(negedge sys_clock);
    check("wr_dphase_hrdata_zero", hrdata, 32'h0);
    @(posedge sys_clock); #1;
    htrans = 2'b00;
    @(negedge sys_clock);
    sb_check();

    // Reset asserted mid-operation
    repeat (20) @(posedge sys_clock);
    #1 reset = 1'b1;
    @(posedge sys_clock);
    @(negedge sys_clock);
    check("midreset_led", 32'(led_out), 32'h0);
    @(posedge sys_clock); #1 reset = 1'b0;
    repeat (5) @(posedge sys_clock);
    @(negedge sys_clock);
    check("postreset_led_low", 32'(led_out), 32'h0);
    for (int i = 0; i < 6; i++) ahb_read(map_offs[i], 32'h0, "postreset_readback");

    check("bus_hready_hresp_const", 32'(bus_bad), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
